// File: rtl/quad_phase_monitor.sv
// Consumer-side checker for the 12 MHz quadrature phase pair (clk1/clk2) in the clock48 domain.
// Optional reverse-direction tracking is enabled by defining QUAD_PHASE_MON_REVERSE_EN.
module quad_phase_monitor #(
  parameter int unsigned LOCK_PERIODS = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock48,
  input  logic             rsted,
  input  logic             ph1_in,
  input  logic             ph2_in,
  output logic             running,
  output logic             locked,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic [CNT_W-1:0] period_count,
  output logic [1:0]       phase,
  output logic             dir
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_TH = 8'(LOCK_PERIODS);

  state_t     state;
  logic [7:0] good;

  logic [1:0] s;
  logic [1:0] exp_step;
  logic       step_ok;
  logic       completes;
  logic       is_stop;
  logic       sync_fwd;
  logic       sync_rev;
  logic [7:0] good_inc;

  function automatic logic [1:0] next_fwd(input logic [1:0] p);
    logic [1:0] n;
    case (p)
      2'b10:   n = 2'b11;
      2'b11:   n = 2'b01;
      2'b01:   n = 2'b00;
      default: n = 2'b10;
    endcase
    return n;
  endfunction

`ifdef QUAD_PHASE_MON_REVERSE_EN
  function automatic logic [1:0] next_rev(input logic [1:0] p);
    logic [1:0] n;
    case (p)
      2'b01:   n = 2'b11;
      2'b11:   n = 2'b10;
      2'b10:   n = 2'b00;
      default: n = 2'b01;
    endcase
    return n;
  endfunction
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign s = {ph1_in, ph2_in};

  // The registered phase doubles as the previous sample p.
  always_comb begin
`ifdef QUAD_PHASE_MON_REVERSE_EN
    exp_step = dir ? next_rev(phase) : next_fwd(phase);
    sync_rev = (phase == 2'b00) && (s == 2'b01);
`else
    exp_step = next_fwd(phase);
    sync_rev = 1'b0;
`endif
    step_ok   = (s == exp_step);
    // In both directions the period-completing step is the one landing on 00.
    completes = step_ok && (s == 2'b00);
    is_stop   = (phase == 2'b00) && (s == 2'b00);
    sync_fwd  = (phase == 2'b00) && (s == 2'b10);
    good_inc  = sat_inc8(good);
  end

  always_ff @(posedge clock48) begin
    if (rsted) begin
      state        <= IDLE;
      good         <= 8'd0;
      running      <= 1'b0;
      locked       <= 1'b0;
      err_pulse    <= 1'b0;
      err_count    <= 8'd0;
      period_count <= '0;
      phase        <= 2'b00;
      dir          <= 1'b0;
    end else begin
      phase     <= s;
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_fwd) begin
            state   <= TRACK;
            running <= 1'b1;
            dir     <= 1'b0;
            good    <= 8'd0;
          end else if (sync_rev) begin
            state   <= TRACK;
            running <= 1'b1;
            dir     <= 1'b1;
            good    <= 8'd0;
          end
        end
        TRACK, LOCKED: begin
          if (step_ok) begin
            if (completes) begin
              period_count <= period_count + 1'b1;
              good         <= good_inc;
              if ((state == TRACK) && (good_inc >= LOCK_TH)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end else if (is_stop) begin
            // Generator disabled: a clean stop, not an error.
            state   <= IDLE;
            running <= 1'b0;
            locked  <= 1'b0;
            good    <= 8'd0;
          end else begin
            state     <= IDLE;
            running   <= 1'b0;
            locked    <= 1'b0;
            good      <= 8'd0;
            err_pulse <= 1'b1;
            err_count <= sat_inc8(err_count);
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          locked  <= 1'b0;
          good    <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quad_phase_monitor.sv
// Self-checking bench for quad_phase_monitor: vector table, directed corner sequences,
// and randomized samples against a sequence-table reference model.
module tb_quad_phase_monitor;

  localparam int LOCKP = 4;
  localparam int CW    = 10;
`ifdef QUAD_PHASE_MON_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic          clock48 = 1'b0;
  logic          rsted   = 1'b1;
  logic          ph1_in  = 1'b0;
  logic          ph2_in  = 1'b0;
  logic          running;
  logic          locked;
  logic          err_pulse;
  logic [7:0]    err_count;
  logic [CW-1:0] period_count;
  logic [1:0]    phase;
  logic          dir;

  quad_phase_monitor #(.LOCK_PERIODS(LOCKP), .CNT_W(CW)) dut (
    .clock48      (clock48),
    .rsted        (rsted),
    .ph1_in       (ph1_in),
    .ph2_in       (ph2_in),
    .running      (running),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .period_count (period_count),
    .phase        (phase),
    .dir          (dir)
  );

  always #5 clock48 = ~clock48;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit       m_run, m_lock, m_errp, m_dir;
  int       m_good, m_err, m_per;
  logic [1:0] m_prev, m_last;

  typedef struct {
    logic [1:0] s;
    logic       run;
    logic       lock;
    logic       errp;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] seq_next(input logic [1:0] p, input bit d);
    logic [1:0] sq[4];
    if (d) begin
      sq[0] = 2'b01; sq[1] = 2'b11; sq[2] = 2'b10; sq[3] = 2'b00;
    end else begin
      sq[0] = 2'b10; sq[1] = 2'b11; sq[2] = 2'b01; sq[3] = 2'b00;
    end
    for (int i = 0; i < 4; i++)
      if (sq[i] == p) return sq[(i + 1) % 4];
    return 2'b00;
  endfunction

  function automatic logic [31:0] dut_vec();
    return {8'd0, running, locked, err_pulse, dir, phase, err_count, period_count};
  endfunction

  function automatic logic [31:0] model_vec();
    logic [7:0]    ec;
    logic [CW-1:0] pc;
    ec = (m_err > 255) ? 8'd255 : 8'(m_err);
    pc = CW'(m_per % (1 << CW));
    return {8'd0, m_run, m_lock, m_errp, m_dir, m_last, ec, pc};
  endfunction

  task automatic model_reset();
    m_run = 0; m_lock = 0; m_errp = 0; m_dir = 0;
    m_good = 0; m_err = 0; m_per = 0;
    m_prev = 2'b00; m_last = 2'b00;
  endtask

  task automatic model_step(input logic [1:0] s);
    m_errp = 0;
    if (!m_run) begin
      if (m_prev == 2'b00 && s == 2'b10) begin
        m_run = 1; m_dir = 0; m_good = 0;
      end else if (REV && m_prev == 2'b00 && s == 2'b01) begin
        m_run = 1; m_dir = 1; m_good = 0;
      end
    end else if (s == seq_next(m_prev, m_dir)) begin
      if (s == 2'b00) begin
        m_per++;
        if (m_good < 255) m_good++;
        if (m_good >= LOCKP) m_lock = 1;
      end
    end else if (m_prev == 2'b00 && s == 2'b00) begin
      m_run = 0; m_lock = 0; m_good = 0;
    end else begin
      m_errp = 1; m_err++; m_run = 0; m_lock = 0; m_good = 0;
    end
    m_prev = s;
    m_last = s;
  endtask

  task automatic do_reset();
    rsted = 1'b1;
    {ph1_in, ph2_in} = 2'b00;
    @(posedge clock48);
    #1;
    rsted = 1'b0;
    model_reset();
    check("reset_state", dut_vec(), 32'd0);
  endtask

  task automatic step(input logic [1:0] s);
    {ph1_in, ph2_in} = s;
    @(posedge clock48);
    #1;
    model_step(s);
    check("model", dut_vec(), model_vec());
  endtask

  task automatic run_periods(input int n, input bit rev);
    for (int k = 0; k < n; k++) begin
      if (rev) begin
        step(2'b01); step(2'b11); step(2'b10); step(2'b00);
      end else begin
        step(2'b10); step(2'b11); step(2'b01); step(2'b00);
      end
    end
  endtask

  initial begin
    logic [1:0] fwd[4];
    logic [1:0] rs;
    int r;
    fwd[0] = 2'b10; fwd[1] = 2'b11; fwd[2] = 2'b01; fwd[3] = 2'b00;

    // Lock after four periods, then an injected 10 where 01 is due, then resync.
    for (int i = 0; i < 16; i++) begin
      tbl[i].s = fwd[i % 4]; tbl[i].run = 1'b1; tbl[i].lock = (i == 15); tbl[i].errp = 1'b0;
    end
    tbl[16] = '{2'b10, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{2'b11, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{2'b10, 1'b0, 1'b0, 1'b1};
    tbl[19] = '{2'b00, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{2'b10, 1'b1, 1'b0, 1'b0};

    do_reset();
    repeat (10) step(2'b00);
    check("idle_running", 32'(running), 32'd0);
    check("idle_locked", 32'(locked), 32'd0);
    check("idle_err_count", 32'(err_count), 32'd0);
    check("idle_period_count", 32'(period_count), 32'd0);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].s);
      check($sformatf("tbl[%0d] run/lock/err", i), {29'd0, running, locked, err_pulse},
            {29'd0, tbl[i].run, tbl[i].lock, tbl[i].errp});
      if (i == 15) check("period_count_after_lock", 32'(period_count), 32'd4);
    end
    check("err_count_after_violation", 32'(err_count), 32'd1);

    // Finish the resync: 11,01,00 plus three more periods re-locks.
    step(2'b11); step(2'b01); step(2'b00);
    run_periods(2, 1'b0);
    step(2'b10); step(2'b11); step(2'b01);
    check("relock_not_early", 32'(locked), 32'd0);
    step(2'b00);
    check("relock", 32'(locked), 32'd1);

    // Clean stop: second consecutive 00 drops running and locked, no error.
    step(2'b00);
    check("stop_running", 32'(running), 32'd0);
    check("stop_locked", 32'(locked), 32'd0);
    check("stop_err_count", 32'(err_count), 32'd1);
    run_periods(4, 1'b0);
    check("restart_locked", 32'(locked), 32'd1);

    // 300 violations: sync on 10, then 00 where 11 is due.
    do_reset();
    step(2'b00);
    for (int k = 0; k < 300; k++) begin
      step(2'b10);
      step(2'b00);
      if (k == 0) check("first_err_pulse", 32'(err_pulse), 32'd1);
    end
    check("err_count_saturated", 32'(err_count), 32'd255);
    step(2'b00);
    check("err_pulse_single_cycle", 32'(err_pulse), 32'd0);

    // Reset mid-operation clears the error counter.
    run_periods(2, 1'b0);
    do_reset();
    check("reset_clears_err_count", 32'(err_count), 32'd0);

    // Period counter wrap.
    run_periods((1 << CW) + 3, 1'b0);
    check("period_wrap", 32'(period_count), 32'd3);
    check("wrap_locked", 32'(locked), 32'd1);

    // Reverse order from 00: tracked only when reverse support is built in.
    do_reset();
    step(2'b00);
    run_periods(4, 1'b1);
    check("rev_running", 32'(running), 32'(REV));
    check("rev_locked", 32'(locked), 32'(REV));
    check("rev_dir", 32'(dir), 32'(REV));
    check("rev_err_count", 32'(err_count), 32'd0);
    check("rev_period_count", 32'(period_count), REV ? 32'd4 : 32'd0);

    // Randomized samples, mostly legal steps with stops and glitches mixed in.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 19));
      if (r < 16)      rs = seq_next(m_prev, m_dir);
      else if (r < 18) rs = 2'b00;
      else             rs = 2'($urandom_range(0, 3));
      if (!m_run && m_prev == 2'b00 && r < 16 && REV && r[0]) rs = 2'b01;
      step(rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
